// File: rtl/hf_spi_cmd_rx_if.sv
// SPI pins from the ARM plus the configuration outputs consumed by the HF mode mux.
// The ARM side drives the pins; the receiver drives the configuration outputs.
interface hf_spi_cmd_rx_if;
  logic       spck;
  logic       mosi;
  logic       ncs;
  logic [7:0] conf_word;
  logic       conf_strobe;
  logic [7:0] thresh;
  logic [3:0] subcarrier_div;
  logic [7:0] frame_err_cnt;

  modport master (
    output spck, mosi, ncs,
    input  conf_word, conf_strobe, thresh, subcarrier_div, frame_err_cnt
  );

  modport slave (
    input  spck, mosi, ncs,
    output conf_word, conf_strobe, thresh, subcarrier_div, frame_err_cnt
  );
endinterface

// File: rtl/hf_spi_cmd_rx.sv
// ARM->FPGA SPI command receiver: oversamples spck/mosi/ncs in the 13.56 MHz domain,
// assembles MSB-first frames and updates the HF configuration registers glitch-free.
module hf_spi_cmd_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            ck_1356meg,
  input  logic            reset,
  hf_spi_cmd_rx_if.slave  spi
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  logic [SYNC_STAGES-1:0] spck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   spck_prev;
  logic                   ncs_prev;

  logic spck_s;
  logic mosi_s;
  logic ncs_s;
  logic spck_rise;
  logic ncs_rise;
  logic ncs_fall;

  state_t                state;
  state_t                state_next;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] shift_next;
  logic [4:0]            bit_cnt;
  logic [4:0]            cnt_next;
  logic                  frame_bad;

  logic [3:0] opcode;
  logic       commit;
  logic       bad_opcode;
  logic       err_inc;

  logic [7:0] conf_word_q;
  logic       conf_strobe_q;
  logic [7:0] thresh_q;
  logic [3:0] div_q;
  logic [7:0] err_cnt_q;

  // The ncs chain resets to 0 so that ncs held low across reset release never
  // looks like a fresh fall; only a real high->low transition opens a frame.
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      spck_sync <= '0;
      mosi_sync <= '0;
      ncs_sync  <= '0;
      spck_prev <= 1'b0;
      ncs_prev  <= 1'b0;
    end else begin
      spck_sync <= {spck_sync[SYNC_STAGES-2:0], spi.spck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      spck_prev <= spck_sync[SYNC_STAGES-1];
      ncs_prev  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign spck_s    = spck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign spck_rise = spck_s & ~spck_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
    end
  end

  // A bit arriving in the same cycle as ncs rise is shifted before the length check.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    cnt_next   = bit_cnt;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          shift_next = '0;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (spck_rise) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], mosi_s};
          if (bit_cnt != CNT_MAX) begin
            cnt_next = bit_cnt + 5'd1;
          end
        end
        if (ncs_rise) begin
          if (cnt_next == FRAME_CNT) begin
            state_next = COMMIT;
          end else begin
            state_next = IDLE;
            frame_bad  = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign commit     = (state == COMMIT);
  assign opcode     = shift_reg[FRAME_BITS-1 -: 4];
  assign bad_opcode = commit && (opcode != 4'd1) && (opcode != 4'd2) && (opcode != 4'd3);
  assign err_inc    = frame_bad | bad_opcode;

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      conf_word_q   <= 8'hE0;
      conf_strobe_q <= 1'b0;
      thresh_q      <= 8'd8;
      div_q         <= 4'd0;
      err_cnt_q     <= 8'd0;
    end else begin
      conf_strobe_q <= commit && (opcode == 4'd1);
      if (commit && (opcode == 4'd1)) begin
        conf_word_q <= shift_reg[7:0];
      end
      if (commit && (opcode == 4'd2)) begin
        thresh_q <= shift_reg[7:0];
      end
      if (commit && (opcode == 4'd3)) begin
        div_q <= shift_reg[3:0];
      end
      if (err_inc && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign spi.conf_word      = conf_word_q;
  assign spi.conf_strobe    = conf_strobe_q;
  assign spi.thresh         = thresh_q;
  assign spi.subcarrier_div = div_q;
  assign spi.frame_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_hf_spi_cmd_rx.sv
// Bench for hf_spi_cmd_rx: scripted and randomized SPI frames checked against a
// frame-level model of the configuration registers, plus literal spot values.
module tb_hf_spi_cmd_rx;

  logic ck_1356meg;
  logic reset;
  hf_spi_cmd_rx_if bus();

  hf_spi_cmd_rx #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .ck_1356meg (ck_1356meg),
    .reset      (reset),
    .spi        (bus)
  );

  initial ck_1356meg = 1'b0;
  always #37 ck_1356meg = ~ck_1356meg;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int strobe_total = 0;
  bit settled = 1'b0;

  logic [7:0] m_conf;
  logic [7:0] m_thresh;
  logic [3:0] m_div;
  int         m_err;
  logic [7:0] m_pend_conf;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge ck_1356meg);
    #1;
  endtask

  function automatic void modelReset();
    m_conf   = 8'hE0;
    m_thresh = 8'd8;
    m_div    = 4'd0;
    m_err    = 0;
  endfunction

  // Frame-level model: what a completed frame of nbits does to the registers.
  function automatic void modelFrame(input logic [15:0] word, input int nbits);
    if (nbits != 16) begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end else begin
      case (word[15:12])
        4'd1: m_conf   = word[7:0];
        4'd2: m_thresh = word[7:0];
        4'd3: m_div    = word[3:0];
        default: m_err = (m_err < 255) ? m_err + 1 : 255;
      endcase
    end
  endfunction

  // Continuous compare: registers must match the model whenever no frame is in flight.
  always @(negedge ck_1356meg) begin
    if (bus.conf_strobe === 1'b1) begin
      strobe_total++;
      checkOutput("strobe_word", bus.conf_word, m_pend_conf);
    end
    if (settled && !reset) begin
      checkOutput("conf_word", bus.conf_word, m_conf);
      checkOutput("thresh", bus.thresh, m_thresh);
      checkOutput("subcarrier_div", bus.subcarrier_div, m_div);
      checkOutput("frame_err_cnt", bus.frame_err_cnt, m_err);
      checkOutput("strobe_idle", bus.conf_strobe, 0);
    end
  end

  task automatic applyStimulus(input logic [15:0] word, input int nbits, input int half, input bit joint);
    int  strobes_before;
    int  exp_strobes;
    logic b;
    exp_strobes = (nbits == 16 && word[15:12] == 4'd1) ? 1 : 0;
    if (exp_strobes == 1) m_pend_conf = word[7:0];
    strobes_before = strobe_total;
    bus.ncs = 1'b0;
    waitCycles(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) b = word[15-i];
      else        b = 1'($urandom);
      bus.mosi = b;
      waitCycles(half);
      if (joint && i == nbits - 1) begin
        settled = 1'b0;
        bus.spck = 1'b1;
        bus.ncs  = 1'b1;
      end else begin
        bus.spck = 1'b1;
      end
      waitCycles(half);
      bus.spck = 1'b0;
    end
    if (!joint || nbits == 0) begin
      waitCycles(3);
      settled = 1'b0;
      bus.ncs = 1'b1;
    end
    waitCycles(10);
    modelFrame(word, nbits);
    checkOutput("strobe_count", strobe_total - strobes_before, exp_strobes);
    settled = 1'b1;
    waitCycles(3);
  endtask

  task automatic sendBits(input logic [15:0] word, input int nbits, input int half);
    bus.ncs = 1'b0;
    waitCycles(4);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = word[15-i];
      waitCycles(half);
      bus.spck = 1'b1;
      waitCycles(half);
      bus.spck = 1'b0;
    end
  endtask

  task automatic pulseReset(input bit release_ncs_first);
    settled = 1'b0;
    reset = 1'b1;
    waitCycles(3);
    if (release_ncs_first) bus.ncs = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    modelReset();
    waitCycles(2);
    settled = 1'b1;
  endtask

  task automatic spckNoise(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mosi = 1'($urandom);
      waitCycles(4);
      bus.spck = 1'b1;
      waitCycles(4);
      bus.spck = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] w;
    int nb;
    int r;
    bus.spck = 1'b0;
    bus.mosi = 1'b0;
    bus.ncs  = 1'b1;
    reset    = 1'b1;
    m_pend_conf = 8'hE0;
    modelReset();
    waitCycles(5);
    reset = 1'b0;
    waitCycles(1);
    settled = 1'b1;
    waitCycles(10);
    checkOutput("lit_reset_conf", bus.conf_word, 8'hE0);
    checkOutput("lit_reset_thresh", bus.thresh, 8'h08);
    checkOutput("lit_reset_div", bus.subcarrier_div, 4'h0);
    checkOutput("lit_reset_err", bus.frame_err_cnt, 8'h00);

    applyStimulus(16'h1023, 16, 6, 1'b0);
    checkOutput("lit_conf_23", bus.conf_word, 8'h23);
    checkOutput("lit_thresh_kept", bus.thresh, 8'h08);

    applyStimulus(16'h2055, 16, 6, 1'b0);
    applyStimulus(16'h300B, 16, 6, 1'b0);
    checkOutput("lit_thresh_55", bus.thresh, 8'h55);
    checkOutput("lit_div_b", bus.subcarrier_div, 4'hB);
    checkOutput("lit_err_0", bus.frame_err_cnt, 8'h00);

    applyStimulus(16'h1077, 15, 6, 1'b0);
    checkOutput("lit_short_conf", bus.conf_word, 8'h23);
    checkOutput("lit_short_err", bus.frame_err_cnt, 8'h01);
    applyStimulus(16'h7012, 16, 6, 1'b0);
    checkOutput("lit_badop_err", bus.frame_err_cnt, 8'h02);

    sendBits(16'h10FF, 10, 6);
    pulseReset(1'b1);
    waitCycles(3);
    applyStimulus(16'h1042, 16, 6, 1'b0);
    checkOutput("lit_conf_42", bus.conf_word, 8'h42);
    checkOutput("lit_err_after_rst", bus.frame_err_cnt, 8'h00);

    // Frame whose final spck rise coincides with ncs rise still counts as complete.
    applyStimulus(16'h2099, 16, 4, 1'b1);
    checkOutput("lit_joint_thresh", bus.thresh, 8'h99);

    // ncs held low across reset release must not open a frame.
    sendBits(16'h3005, 5, 4);
    pulseReset(1'b0);
    spckNoise(16);
    settled = 1'b0;
    bus.ncs = 1'b1;
    waitCycles(10);
    settled = 1'b1;
    spckNoise(5);
    checkOutput("lit_phantom_err", bus.frame_err_cnt, 8'h00);
    checkOutput("lit_phantom_div", bus.subcarrier_div, 4'h0);

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: w = {4'd1, 12'($urandom)};
        3, 4:    w = {4'd2, 12'($urandom)};
        5, 6:    w = {4'd3, 12'($urandom)};
        default: w = 16'($urandom);
      endcase
      r = int'($urandom_range(0, 9));
      nb = (r == 0) ? 15 : (r == 1) ? 17 : (r == 2) ? int'($urandom_range(1, 14)) : 16;
      applyStimulus(w, nb, int'($urandom_range(3, 8)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) spckNoise(int'($urandom_range(1, 3)));
    end

    for (int k = 0; k < 300; k++) begin
      applyStimulus(16'hF000, 16, 3, 1'b0);
    end
    checkOutput("lit_err_sat", bus.frame_err_cnt, 8'hFF);
    applyStimulus(16'h10C1, 16, 3, 1'b0);
    checkOutput("lit_conf_c1", bus.conf_word, 8'hC1);
    checkOutput("lit_err_still_sat", bus.frame_err_cnt, 8'hFF);

    settled = 1'b0;
    waitCycles(2);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
